// File: rtl/move_input_latch_pkg.sv
// Shared constants for the push-button conditioning stage that feeds the
// tic-tac-toe datapath.
package move_input_latch_pkg;

    localparam int CELLS               = 9;
    localparam int DEBOUNCE_CYCLES_DEF = 250000;  // 5 ms at 50 MHz
    localparam int CNT_W_DEF           = 18;

endpackage

// File: rtl/debounce_vec.sv
// Two-flop synchronizer plus whole-vector debouncer: a new vector value is
// accepted only after it has been stable for DEBOUNCE_CYCLES synchronized cycles.
module debounce_vec #(
    parameter int WIDTH           = 9,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [0:WIDTH-1] raw,
    output logic [0:WIDTH-1] deb,
    output logic             accept,
    output logic [0:WIDTH-1] rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [0:WIDTH-1] meta_q, meta_d;
    logic [0:WIDTH-1] sync_q, sync_d;
    logic [0:WIDTH-1] prev_q, prev_d;
    logic [0:WIDTH-1] deb_q,  deb_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic             accept_c;

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no latch is inferred.
        meta_d   = raw;
        sync_d   = meta_q;
        prev_d   = sync_q;
        deb_d    = deb_q;
        cnt_d    = cnt_q + CNT_W'(1);
        accept_c = (sync_q != deb_q) && (sync_q == prev_q) && (cnt_q == CNT_LAST);

        // Any bounce, or a vector that already matches deb, restarts the count.
        if ((sync_q != prev_q) || (sync_q == deb_q)) begin
            cnt_d = '0;
        end else if (accept_c) begin
            deb_d = sync_q;
            cnt_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
            deb_q  <= '0;
            cnt_q  <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
            deb_q  <= deb_d;
            cnt_q  <= cnt_d;
        end
    end

    assign deb    = deb_q;
    assign accept = accept_c;
    assign rise   = accept_c ? (sync_q & ~deb_q) : '0;

endmodule

// File: rtl/move_input_latch.sv
// Conditions raw player/restart buttons into sticky per-player move vectors,
// new-move pulses and a single-cycle restart pulse.
module move_input_latch
    import move_input_latch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [0:CELLS-1] btn1_raw,
    input  logic [0:CELLS-1] btn2_raw,
    input  logic             restart_raw,
    output logic [0:CELLS-1] p1,
    output logic [0:CELLS-1] p2,
    output logic             new_move1,
    output logic             new_move2,
    output logic             restart
);

    logic [0:CELLS-1] deb_a, rise_a, deb_b, rise_b;
    logic [0:0]       deb_c, rise_c;
    logic             accept_a, accept_b, accept_c;

    debounce_vec #(.WIDTH(CELLS), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_a (
        .clock  (clock),
        .reset  (reset),
        .raw    (btn1_raw),
        .deb    (deb_a),
        .accept (accept_a),
        .rise   (rise_a)
    );

    debounce_vec #(.WIDTH(CELLS), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_b (
        .clock  (clock),
        .reset  (reset),
        .raw    (btn2_raw),
        .deb    (deb_b),
        .accept (accept_b),
        .rise   (rise_b)
    );

    debounce_vec #(.WIDTH(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_c (
        .clock  (clock),
        .reset  (reset),
        .raw    (restart_raw),
        .deb    (deb_c),
        .accept (accept_c),
        .rise   (rise_c)
    );

    // Debounced levels are only needed for observability; the latch works on rise masks.
    logic unused_deb;
    assign unused_deb = ^{deb_a, deb_b, deb_c};

    logic [0:CELLS-1] p1_q, p1_d, p2_q, p2_d;
    logic             new_move1_q, new_move1_d;
    logic             new_move2_q, new_move2_d;
    logic             restart_q, restart_d;

    always_comb begin
        p1_d        = p1_q;
        p2_d        = p2_q;
        new_move1_d = 1'b0;
        new_move2_d = 1'b0;
        restart_d   = accept_c & rise_c[0];

        // A pending restart clears the board and drops any press landing on the same edge.
        if (restart_q) begin
            p1_d = '0;
            p2_d = '0;
        end else begin
            if (accept_a) begin
                p1_d        = p1_q | rise_a;
                new_move1_d = |(rise_a & ~p1_q);
            end
            if (accept_b) begin
                p2_d        = p2_q | rise_b;
                new_move2_d = |(rise_b & ~p2_q);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            p1_q        <= '0;
            p2_q        <= '0;
            new_move1_q <= 1'b0;
            new_move2_q <= 1'b0;
            restart_q   <= 1'b0;
        end else begin
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            new_move1_q <= new_move1_d;
            new_move2_q <= new_move2_d;
            restart_q   <= restart_d;
        end
    end

    assign p1        = p1_q;
    assign p2        = p2_q;
    assign new_move1 = new_move1_q;
    assign new_move2 = new_move2_q;
    assign restart   = restart_q;

endmodule

// File: tb/tb_move_input_latch.sv
// Directed and random stimulus for move_input_latch, checked every cycle
// against a sliding-window reference model of the button conditioning rules.
module tb_move_input_latch;

    localparam int DC = 4;
    localparam int HL = DC + 3;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [0:8] btn1_raw = '0;
    logic [0:8] btn2_raw = '0;
    logic       restart_raw = 1'b0;
    logic [0:8] p1, p2;
    logic       new_move1, new_move2, restart;

    always #5 clock = ~clock;

    move_input_latch #(.DEBOUNCE_CYCLES(DC), .CNT_W(18)) dut (
        .clock       (clock),
        .reset       (reset),
        .btn1_raw    (btn1_raw),
        .btn2_raw    (btn2_raw),
        .restart_raw (restart_raw),
        .p1          (p1),
        .p2          (p2),
        .new_move1   (new_move1),
        .new_move2   (new_move2),
        .restart     (restart)
    );

    // Reference model: hist[g][0] is the raw sample taken at the latest edge.
    logic [0:8] hist [3][HL];
    logic [0:8] deb_m [3];
    logic [0:8] p1_m, p2_m;
    logic       nm1_m, nm2_m, rst_m;

    int errors = 0;
    int checks = 0;
    int nm1_seen = 0, nm2_seen = 0, rst_seen = 0;

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int g = 0; g < 3; g++) begin
            for (int k = 0; k < HL; k++) hist[g][k] = '0;
            deb_m[g] = '0;
        end
        p1_m = '0; p2_m = '0;
        nm1_m = 1'b0; nm2_m = 1'b0; rst_m = 1'b0;
    endtask

    // A group accepts when the DC+1 synchronized samples (two edges old and older)
    // agree with each other and differ from the current debounced value.
    task automatic model_edge(input logic [0:8] s0, input logic [0:8] s1, input logic [0:8] s2);
        logic [0:8] sm [3];
        logic       acc [3];
        logic [0:8] rs [3];
        logic [0:8] np1, np2;
        logic       n1, n2;
        sm[0] = s0; sm[1] = s1; sm[2] = s2;
        for (int g = 0; g < 3; g++) begin
            for (int k = HL - 1; k > 0; k--) hist[g][k] = hist[g][k-1];
            hist[g][0] = sm[g];
            acc[g] = (hist[g][2] != deb_m[g]);
            for (int k = 3; k < HL; k++) if (hist[g][k] != hist[g][2]) acc[g] = 1'b0;
            rs[g] = acc[g] ? (hist[g][2] & ~deb_m[g]) : '0;
        end
        np1 = p1_m; np2 = p2_m; n1 = 1'b0; n2 = 1'b0;
        if (rst_m) begin
            np1 = '0; np2 = '0;
        end else begin
            np1 = p1_m | rs[0]; n1 = (rs[0] & ~p1_m) != 0;
            np2 = p2_m | rs[1]; n2 = (rs[1] & ~p2_m) != 0;
        end
        rst_m = rs[2][8];
        p1_m = np1; p2_m = np2; nm1_m = n1; nm2_m = n2;
        for (int g = 0; g < 3; g++) if (acc[g]) deb_m[g] = hist[g][2];
    endtask

    task automatic compare_all();
        check("p1", p1, p1_m);
        check("p2", p2, p2_m);
        check("new_move1", 9'(new_move1), 9'(nm1_m));
        check("new_move2", 9'(new_move2), 9'(nm2_m));
        check("restart", 9'(restart), 9'(rst_m));
    endtask

    task automatic step();
        logic [0:8] s0, s1, s2;
        s0 = btn1_raw; s1 = btn2_raw; s2 = {8'b0, restart_raw};
        @(posedge clock);
        if (!reset) model_reset();
        else model_edge(s0, s1, s2);
        #1;
        if (new_move1) nm1_seen++;
        if (new_move2) nm2_seen++;
        if (restart) rst_seen++;
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        model_reset();

        // Reset held with every button pressed: outputs must stay clear.
        btn1_raw = '1; btn2_raw = '1; restart_raw = 1'b1;
        run(4);
        check("rst_p1", p1, 9'b0);
        check("rst_p2", p2, 9'b0);
        check("rst_pulse", 9'({new_move1, new_move2, restart}), 9'b0);

        // Release reset with only cell 4 held: latched on the 7th edge.
        btn1_raw = 9'b000010000; btn2_raw = '0; restart_raw = 1'b0;
        reset = 1'b1;
        nm1_seen = 0;
        run(6);
        check("lat_p1_early", p1, 9'b0);
        step();
        check("lat_p1", p1, 9'b000010000);
        check("lat_nm1", 9'(new_move1), 9'd1);
        run(6);
        check("lat_pulses", 9'(nm1_seen), 9'd1);

        // Bounce on btn2[0]: ten toggles two cycles apart, then a final hold.
        nm2_seen = 0;
        for (int i = 0; i < 10; i++) begin
            btn2_raw[0] = ~btn2_raw[0];
            run(2);
        end
        check("bnc_p2_during", p2, 9'b0);
        btn2_raw[0] = 1'b1;
        run(6);
        check("bnc_p2_early", p2, 9'b0);
        step();
        check("bnc_p2", p2, 9'b100000000);
        check("bnc_pulses", 9'(nm2_seen), 9'd1);

        // Sticky: press, release, press again on cell 2; releases never clear bits.
        btn1_raw = '0; btn2_raw = '0;
        run(8);
        nm1_seen = 0;
        btn1_raw[2] = 1'b1; run(8);
        btn1_raw[2] = 1'b0; run(8);
        check("stk_p1_released", p1, 9'b001010000);
        btn1_raw[2] = 1'b1; run(8);
        check("stk_p1", p1, 9'b001010000);
        check("stk_pulses", 9'(nm1_seen), 9'd1);
        btn1_raw[2] = 1'b0; run(8);

        // Simultaneous press on cell 3 by both players.
        btn1_raw[3] = 1'b1; btn2_raw[3] = 1'b1;
        run(6);
        check("sim_p1_early", 9'(p1[3]), 9'd0);
        step();
        check("sim_p1", p1, 9'b001110000);
        check("sim_p2", p2, 9'b100100000);
        check("sim_nm", 9'({new_move1, new_move2}), 9'b11);
        btn1_raw = '0; btn2_raw = '0;
        run(8);

        // Restart race: btn1[8] accepts on the edge where restart is high.
        nm1_seen = 0; rst_seen = 0;
        restart_raw = 1'b1; step();
        btn1_raw[8] = 1'b1; run(5);
        step();
        check("race_restart", 9'(restart), 9'd1);
        step();
        check("race_p1", p1, 9'b0);
        check("race_p2", p2, 9'b0);
        check("race_nm1", 9'(new_move1), 9'd0);
        check("race_restart_off", 9'(restart), 9'd0);
        run(10);
        restart_raw = 1'b0; btn1_raw = '0;
        run(10);
        check("race_p1_stays", p1, 9'b0);
        check("race_nm1_cnt", 9'(nm1_seen), 9'd0);
        check("race_rst_cnt", 9'(rst_seen), 9'd1);

        // Async reset mid-debounce with btn2[5] held.
        btn1_raw[0] = 1'b1; run(8);
        btn1_raw[0] = 1'b0; run(8);
        check("ar_p1_set", p1, 9'b100000000);
        btn2_raw[5] = 1'b1;
        run(5);
        reset = 1'b0;
        model_reset();
        #1;
        check("ar_p1_clear", p1, 9'b0);
        compare_all();
        run(2);
        reset = 1'b1;
        nm2_seen = 0;
        run(6);
        check("ar_p2_early", p2, 9'b0);
        step();
        check("ar_p2", p2, 9'b000001000);
        check("ar_nm2", 9'(new_move2), 9'd1);
        btn2_raw = '0;
        run(8);

        // Random presses, releases and short bounces on all three groups.
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 5)       btn1_raw[$urandom_range(0, 8)] ^= 1'b1;
            else if (r < 10) btn2_raw[$urandom_range(0, 8)] ^= 1'b1;
            else if (r < 12) restart_raw = ~restart_raw;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/move_input_latch.md
Name: move_input_latch

Overview:
- Input-conditioning stage directly upstream of the tic-tac-toe top.
- Takes raw, bouncing, asynchronous momentary push-buttons: 9 cells per player plus a restart button.
- Produces clean, synchronous, sticky 9-bit per-player move vectors (p1, p2) and a one-cycle restart pulse, which feed the game datapath/FSM directly.
- Legality checking (occupied cell, turn order, multiple cells) is not done here; the downstream datapath owns it.

Parameters:
- DEBOUNCE_CYCLES, 250000, number of consecutive stable synchronized cycles before a change is accepted (5 ms at 50 MHz); legal range 2 to 2^CNT_W-1.
- CNT_W, 18, width of each debounce counter.

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- btn1_raw  input  [0:8]  player-1 cell buttons, raw, active-high, asynchronous.
- btn2_raw  input  [0:8]  player-2 cell buttons, raw, active-high, asynchronous.
- restart_raw  input  1  restart button, raw, active-high, asynchronous.
- p1  output  [0:8]  sticky player-1 move vector (bit i = cell i pressed since last restart).
- p2  output  [0:8]  sticky player-2 move vector.
- new_move1  output  1  one-cycle pulse: p1 gained at least one bit on this edge.
- new_move2  output  1  one-cycle pulse: p2 gained at least one bit on this edge.
- restart  output  1  one-cycle pulse on each clean restart press.

Behaviour:
- Reset (reset=0, asynchronous) clears all of the following to 0: synchronizers, debounced values, counters, p1, p2, new_move1, new_move2, restart.
- Synchronizer: each raw bit passes through 2 flops. The result is "sync".
- Debounce per group (group A = btn1, 9b; group B = btn2, 9b; group C = restart, 1b). Each group has registers sync_prev, deb and cnt.
  - Whole-vector compare, not per-bit.
  - cnt clears to 0 when sync != sync_prev or sync == deb; otherwise cnt increments.
  - When sync != deb, sync == sync_prev and cnt == DEBOUNCE_CYCLES-1: deb <= sync and cnt <= 0 on that edge. This is the "accept edge".
  - Any bounce restarts the count.
- Latency: a clean raw rise held steady is accepted at clock edge DEBOUNCE_CYCLES+3 after the first sampling edge (2 sync + 1 change-detect + DEBOUNCE_CYCLES stable).
- Latching:
  - On a group A accept edge: p1 <= p1 | (sync & ~deb). Only rising bits set; releases (falling bits) have no effect on p1.
  - Group B drives p2 the same way.
- new_moveN is registered on the same edge as the latch update. It is 1 iff (sync & ~deb & ~pN) != 0 for that group, i.e. at least one genuinely new bit. Re-pressing an already-set cell gives no pulse.
- Restart:
  - On a group C accept edge with sync=1, restart <= 1 for exactly one cycle. Release produces no pulse.
  - On the edge where restart is 1: p1 and p2 clear to 0, and new_move1/new_move2 are forced to 0. Clear wins over any latch update on that same edge; the dropped press is not replayed.
- Simultaneous events:
  - Multiple bits rising in one accept edge all latch.
  - p1 and p2 latching the same cell on the same edge both latch; the datapath flags it invalid.
  - Groups are independent, so A, B and C accepts may coincide.
- A held button never re-triggers. A new latch requires release to be accepted, then a press to be accepted.
- Reset asserted mid-debounce aborts the count. After reset deasserts, a still-held button is accepted as a fresh press after the full latency.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Shared package: CELLS = 9, default DEBOUNCE_CYCLES, CNT_W.
- Sub-module debounce_vec, parameterized by WIDTH, DEBOUNCE_CYCLES and CNT_W. It contains the synchronizer, sync_prev, cnt and deb, and outputs deb, the accept strobe and the rising mask (sync & ~deb at accept).
- Instantiated three times (WIDTH 9, 9, 1). Latch and pulse logic stay in the parent.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset state: hold reset=0 with all buttons pressed. All outputs stay 0. After release with btn1_raw[4] held, p1=9'b000010000 with one new_move1 pulse, 7 edges after the first sampling edge, and no further pulses.
- Bounce rejection: toggle btn2_raw[0] every 2 cycles for 20 cycles, then hold it. p2 stays 0 until 7 edges after the last toggle, then p2[0]=1.
- Sticky and repeat: press, release, then press btn1_raw[2] again. p1[2] stays 1 throughout, with exactly one new_move1 pulse. Releasing any button never clears a bit.
- Simultaneous press: btn1_raw[3] and btn2_raw[3] rise together. Both p1[3] and p2[3] set on the same edge, and new_move1 and new_move2 pulse together.
- Restart versus latch race: time restart_raw and btn1_raw[8] so their accept edges coincide. restart pulses for 1 cycle, p1=0 and p2=0 on the following edge, and p1[8] stays 0 with no new_move1 pulse.
- Async reset mid-debounce: assert reset at cnt=2 with btn2_raw[5] held. Everything clears immediately, without waiting for a clock edge. After deassert, p2[5] sets after a full 7 edges.
